// File: rtl/approx_ks_add_scheduler.sv
// approx_ks_add_scheduler
//   Round-robin scheduler that shares one 16-bit approximate Kogge-Stone
//   adder among N_REQ requesters. The approximation boundary is at bit 8.
//   The pipeline has two stages: an operand register (S1), then the
//   combinational adder, then a result register (S2). Each result is tagged
//   with the ID of the requester that issued it.
//
//   Optional feature: define ERR_MONITOR_EN to add an exact reference adder.
//   It drives the err_flag and err_cnt outputs.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_valid/ready   per-requester handshake; req_ready is a one-hot grant
//   req_a, req_b      16-bit operands, slice i = [16*i+15:16*i]
//   flush             synchronous clear of both pipeline stages
//   res_valid/ready   result handshake
//   res_sum           17-bit approximate sum (bit 16 = carry out)
//   res_id            requester index for res_sum
//   err_flag, err_cnt (ERR_MONITOR_EN) approx != exact, saturating count
module approx_ks_add_scheduler #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [16*N_REQ-1:0]  req_a,
  input  logic [16*N_REQ-1:0]  req_b,
  input  logic                 flush,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [16:0]          res_sum,
  output logic [ID_W-1:0]      res_id
`ifdef ERR_MONITOR_EN
  ,
  output logic                 err_flag,
  output logic [15:0]          err_cnt
`endif
);

  // Low byte: each bit sees only the generate of the bit below it.
  // High byte: exact, with carry-in a7&b7.
  function automatic logic [16:0] approx_add(input logic [15:0] a, input logic [15:0] b);
    logic [7:0] lo;
    logic [8:0] hi;
    lo[0] = a[0] ^ b[0];
    for (int i = 1; i < 8; i++) begin
      lo[i] = (a[i] ^ b[i]) ^ (a[i-1] & b[i-1]);
    end
    hi = {1'b0, a[15:8]} + {1'b0, b[15:8]} + {8'd0, a[7] & b[7]};
    return {hi, lo};
  endfunction

  logic [ID_W-1:0]  ptr_r;
  logic             run_r;
  logic             v1_r;
  logic [15:0]      a1_r;
  logic [15:0]      b1_r;
  logic [ID_W-1:0]  id1_r;

  logic             stall_s;
  logic             found_s;
  logic [ID_W-1:0]  win_s;
  logic [ID_W-1:0]  idx_s;
  logic [N_REQ-1:0] grant_s;
  logic             xfer_s;
  logic [15:0]      a_sel_s;
  logic [15:0]      b_sel_s;

  assign stall_s   = res_valid & ~res_ready;
  assign req_ready = grant_s;
  assign xfer_s    = |grant_s;

  // Round-robin search starting after the pointer. Grants are suppressed
  // until the first clock edge after reset.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    idx_s   = '0;
    grant_s = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx_s = ID_W'((int'(ptr_r) + k) % N_REQ);
      if (!found_s && req_valid[idx_s]) begin
        found_s = 1'b1;
        win_s   = idx_s;
      end else begin
        found_s = found_s;
      end
    end
    if (found_s && !stall_s && !flush && run_r) begin
      grant_s[win_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  // Select the winning requester's operands.
  always_comb begin
    a_sel_s = 16'd0;
    b_sel_s = 16'd0;
    for (int k = 0; k < N_REQ; k++) begin
      if (ID_W'(k) == win_s) begin
        a_sel_s = req_a[16*k +: 16];
        b_sel_s = req_b[16*k +: 16];
      end else begin
        a_sel_s = a_sel_s;
      end
    end
  end

  // Round-robin pointer and post-reset run flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= ID_W'(N_REQ - 1);
      run_r <= 1'b0;
    end else begin
      run_r <= 1'b1;
      if (xfer_s) begin
        ptr_r <= win_s;
      end else begin
        ptr_r <= ptr_r;
      end
    end
  end

  // S1 operand register; holds while the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r  <= 1'b0;
      a1_r  <= 16'd0;
      b1_r  <= 16'd0;
      id1_r <= '0;
    end else if (flush) begin
      v1_r <= 1'b0;
    end else if (!stall_s) begin
      v1_r <= xfer_s;
      if (xfer_s) begin
        a1_r  <= a_sel_s;
        b1_r  <= b_sel_s;
        id1_r <= win_s;
      end
    end
  end

  // S2 result register; data only reloads when S1 carries a valid operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_sum   <= 17'd0;
      res_id    <= '0;
`ifdef ERR_MONITOR_EN
      err_flag  <= 1'b0;
`endif
    end else if (flush) begin
      res_valid <= 1'b0;
    end else if (!stall_s) begin
      res_valid <= v1_r;
      if (v1_r) begin
        res_sum  <= approx_add(a1_r, b1_r);
        res_id   <= id1_r;
`ifdef ERR_MONITOR_EN
        err_flag <= approx_add(a1_r, b1_r) != ({1'b0, a1_r} + {1'b0, b1_r});
`endif
      end
    end
  end

`ifdef ERR_MONITOR_EN
  // Count accepted mismatching results. A flush cancels acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 16'd0;
    end else if (res_valid && res_ready && !flush && err_flag && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end else begin
      err_cnt <= err_cnt;
    end
  end
`endif

endmodule
